// File: rtl/dff_arb_pkg.sv
// Shared types and default sizing for the shared-register round-robin arbiter.
package dff_arb_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic [1:0] {IDLE, WRITE, RELEASE} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) searching
// ptr+1, ptr+2, ... modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] winner
);
  logic [N-1:0]   cand;
  logic [IDW-1:0] sel;

  assign cand = req & mask;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    sel    = '0;
    for (int k = 1; k <= N; k++) begin
      sel = IDW'((int'(ptr) + k) % N);
      if (!found && cand[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end
endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register.
// Optional requester lock is enabled by defining ARB_LOCK_EN.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int N   = DEF_N,
  parameter  int W   = DEF_W,
  localparam int IDW = $clog2(N)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   data,
  input  logic [N-1:0]     lock,
  output logic [W-1:0]     Q,
  output logic [N-1:0]     ack,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy,
  output arb_state_t       state_dbg
);
  // Handshake: requester raises req[i] with data stable; ack[i] rises one edge
  // after the grant, together with Q; requester drops req[i]; ack[i] then falls.

  arb_state_t     state, state_n;
  logic [IDW-1:0] ptr, ptr_n, gnt_n, win;
  logic [W-1:0]   q_n;
  logic [N-1:0]   ack_n, mask;
  logic           busy_n, found;
  logic [W-1:0]   data_w [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_w[i] = data[i*W +: W];
  end

`ifdef ARB_LOCK_EN
  logic           lock_valid, lock_valid_n;
  logic [IDW-1:0] lock_id, lock_id_n;

  always_comb begin
    mask = '1;
    if (lock_valid) begin
      mask          = '0;
      mask[lock_id] = 1'b1;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign mask        = '1;
`endif

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .mask   (mask),
    .ptr    (ptr),
    .found  (found),
    .winner (win)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      ptr    <= IDW'(N - 1);
      Q      <= '0;
      ack    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_valid <= 1'b0;
      lock_id    <= '0;
`endif
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      Q      <= q_n;
      ack    <= ack_n;
      gnt_id <= gnt_n;
      busy   <= busy_n;
`ifdef ARB_LOCK_EN
      lock_valid <= lock_valid_n;
      lock_id    <= lock_id_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    q_n     = Q;
    ack_n   = ack;
    gnt_n   = gnt_id;
    busy_n  = busy;
`ifdef ARB_LOCK_EN
    lock_valid_n = lock_valid;
    lock_id_n    = lock_id;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n   = win;
          busy_n  = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        // Capture regardless of req level; an early drop just shortens RELEASE.
        q_n            = data_w[gnt_id];
        ack_n          = '0;
        ack_n[gnt_id]  = 1'b1;
        state_n        = RELEASE;
      end
      RELEASE: begin
        if (!req[gnt_id]) begin
          ack_n   = '0;
          ptr_n   = gnt_id;
          busy_n  = 1'b0;
          state_n = IDLE;
`ifdef ARB_LOCK_EN
          if (lock[gnt_id]) begin
            lock_valid_n = 1'b1;
            lock_id_n    = gnt_id;
          end else if (lock_valid && lock_id == gnt_id) begin
            lock_valid_n = 1'b0;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed bench for dff_reg_arbiter (N=4, W=8); lock scenario follows ARB_LOCK_EN.
module tb_dff_reg_arbiter;
  import dff_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data;
  logic [N-1:0]     lock;
  logic [W-1:0]     Q;
  logic [N-1:0]     ack;
  logic [1:0]       gnt_id;
  logic             busy;
  arb_state_t       state_dbg;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  dff_reg_arbiter #(.N(N), .W(W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .req       (req),
    .data      (data),
    .lock      (lock),
    .Q         (Q),
    .ack       (ack),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // driver / checker tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction for requester id: grant, write+ack, release.
  task automatic do_txn(input int id, input logic [7:0] exp_q, input bit reraise);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    step();
    chk($sformatf("grant_busy_%0d", id), 32'(busy), 32'd1);
    chk($sformatf("grant_id_%0d", id), 32'(gnt_id), 32'(id));
    chk($sformatf("grant_noack_%0d", id), 32'(ack), 32'd0);
    step();
    chk($sformatf("write_q_%0d", id), 32'(Q), 32'(exp_q));
    chk($sformatf("write_ack_%0d", id), 32'(ack), 32'(oh));
    req[id] = 1'b0;
    step();
    chk($sformatf("rel_ack_%0d", id), 32'(ack), 32'd0);
    chk($sformatf("rel_busy_%0d", id), 32'(busy), 32'd0);
    if (reraise) req[id] = 1'b1;
  endtask

  initial begin
    Reset = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    data  = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    step();
    chk("rst_q", 32'(Q), 32'h00);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    Reset = 1'b0;

    // all request, each drops after its ack: 0,1,2,3
    do_txn(0, 8'h11, 1'b0);
    do_txn(1, 8'h22, 1'b0);
    do_txn(2, 8'h33, 1'b0);
    do_txn(3, 8'h44, 1'b0);

    // single requester
    data[7:0] = 8'hA5;
    req = 4'b0001;
    do_txn(0, 8'hA5, 1'b0);

    // rotation: grant 2, then 0101 -> 0 then 2
    req = 4'b0100;
    do_txn(2, 8'h33, 1'b0);
    req = 4'b0101;
    do_txn(0, 8'hA5, 1'b0);
    do_txn(2, 8'h33, 1'b0);

    // req drop during WRITE: write still completes, release next edge
    req = 4'b0010;
    step();
    chk("drop_grant", 32'(gnt_id), 32'd1);
    req = 4'b0000;
    step();
    chk("drop_q", 32'(Q), 32'h22);
    chk("drop_ack", 32'(ack), 32'b0010);
    step();
    chk("drop_rel_ack", 32'(ack), 32'd0);
    chk("drop_rel_busy", 32'(busy), 32'd0);
    step();
    chk("idle_hold_q", 32'(Q), 32'h22);
    chk("idle_hold_gnt", 32'(gnt_id), 32'd1);
    chk("idle_state", 32'(state_dbg), 32'(IDLE));

    // reset mid-RELEASE
    data[15:8] = 8'h5A;
    req = 4'b0010;
    step();
    chk("mid_grant", 32'(gnt_id), 32'd1);
    step();
    chk("mid_ack", 32'(ack), 32'b0010);
    step();
    chk("mid_hold_ack", 32'(ack), 32'b0010);
    chk("mid_hold_state", 32'(state_dbg), 32'(RELEASE));
    Reset = 1'b1;
    step();
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_q", 32'(Q), 32'h00);
    Reset = 1'b0;
    do_txn(1, 8'h5A, 1'b0);

`ifdef ARB_LOCK_EN
    // lock on requester 1: 0 waits until the lock is released
    lock = 4'b0010;
    req  = 4'b0010;
    do_txn(1, 8'h5A, 1'b1);
    req[0] = 1'b1;
    do_txn(1, 8'h5A, 1'b1);
    do_txn(1, 8'h5A, 1'b1);
    lock = 4'b0000;
    do_txn(1, 8'h5A, 1'b0);
    do_txn(0, 8'hA5, 1'b0);
`else
    // lock input ignored: 0011 alternates from ptr=1
    lock = 4'b0010;
    req  = 4'b0011;
    do_txn(0, 8'hA5, 1'b1);
    do_txn(1, 8'h5A, 1'b0);
    do_txn(0, 8'hA5, 1'b0);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
